alu_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer in front of the combinational single-step ALU.

---
 rtl/alu_seq_ctrl_if.sv | 30 +++
 rtl/alu_seq_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: request/response handshake bundle for alu_seq_ctrl.
//   req_valid/req_ready/req_op/req_a/req_b  : one operation request
//   resp_valid/resp_ready/resp_data         : result handoff
//   resp_zero/resp_neg/resp_ovf             : result flags
// master = requester/consumer side, slave = the sequencer.
interface alu_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_zero;
  logic             resp_neg;
  logic             resp_ovf;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_zero, resp_neg, resp_ovf
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_zero, resp_neg, resp_ovf
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_pkg: opcode and flag types shared with the single-step ALU.
// alu_seq_ctrl: multi-cycle sequencer driving a combinational single-step ALU.
//   clk, rst (sync, active high)
//   bus      : alu_seq_ctrl_if.slave request/response port
//   alu_in1/alu_in2/alu_op : operands and opcode to the ALU
//   alu_out/alu_flags      : ALU result and flags (only carry is used)
// Shifts (SLL/SRL/SRA by n = min(b, WIDTH)) take n one-bit ALU steps.
// MUL runs WIDTH add/shift step pairs, fixed latency 2*WIDTH+1.
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_opcode_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;
endpackage

module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_seq_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output alu_opcode_t      alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  alu_flags_t       alu_flags
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    MADD  = 3'd2,
    MSHL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_r;
  logic [1:0]       op_r;
  logic             sign_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    cnt_r;
  logic             ovf_r;
  logic             req_ready_r;
  logic             resp_valid_r;
  logic [WIDTH-1:0] resp_data_r;
  logic             resp_zero_r;
  logic             resp_neg_r;
  logic             resp_ovf_r;
  logic [CW-1:0]    n_s;
  logic             unused_flags_s;

  function automatic alu_opcode_t shift_opcode(input logic [1:0] op);
    case (op)
      OP_SLL:  return ALU_SLL;
      OP_SRL:  return ALU_SRL;
      default: return ALU_SRA;
    endcase
  endfunction

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  assign unused_flags_s = ^{alu_flags.zero, alu_flags.neg, alu_flags.ovf};

  // Clamp the requested shift amount to WIDTH steps.
  always_comb begin
    n_s = {CW{1'b0}};
    if (bus.req_b >= WIDTH_V) begin
      n_s = CW'(WIDTH);
    end else begin
      n_s = CW'(bus.req_b);
    end
  end

  // ALU operand/opcode selection from the current state.
  always_comb begin
    alu_in1 = {WIDTH{1'b0}};
    alu_in2 = {WIDTH{1'b0}};
    alu_op  = ALU_ADD;
    case (state_r)
      SHIFT: begin
        alu_in1 = acc_r;
        alu_op  = shift_opcode(op_r);
      end
      MADD: begin
        alu_in1 = acc_r;
        alu_in2 = a_r;
        alu_op  = ALU_ADD;
      end
      MSHL: begin
        alu_in1 = a_r;
        alu_op  = ALU_SLL;
      end
      default: begin
        alu_op = ALU_ADD;
      end
    endcase
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      op_r         <= 2'b00;
      sign_r       <= 1'b0;
      acc_r        <= {WIDTH{1'b0}};
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      cnt_r        <= {CW{1'b0}};
      ovf_r        <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_data_r  <= {WIDTH{1'b0}};
      resp_zero_r  <= 1'b0;
      resp_neg_r   <= 1'b0;
      resp_ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_r <= 1'b0;
            op_r        <= bus.req_op;
            sign_r      <= bus.req_a[WIDTH-1];
            ovf_r       <= 1'b0;
            if (bus.req_op == OP_MUL) begin
              acc_r   <= {WIDTH{1'b0}};
              a_r     <= bus.req_a;
              b_r     <= bus.req_b;
              cnt_r   <= {CW{1'b0}};
              state_r <= MADD;
            end else begin
              acc_r   <= bus.req_a;
              cnt_r   <= n_s;
              state_r <= (n_s == {CW{1'b0}}) ? DONE : SHIFT;
            end
          end
        end
        SHIFT: begin
          // SRA re-imposes the sign latched at accept, regardless of ALU fill.
          if (op_r == OP_SRA) begin
            acc_r <= {sign_r, alu_out[WIDTH-2:0]};
          end else begin
            acc_r <= alu_out;
          end
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= DONE;
          end
        end
        MADD: begin
          if (b_r[0]) begin
            acc_r <= alu_out;
            ovf_r <= ovf_r | alu_flags.carry;
          end
          state_r <= MSHL;
        end
        MSHL: begin
          a_r <= alu_out;
          b_r <= b_r >> 1;
          // Losing a's MSB matters only if a later multiplier bit would add it.
          if (a_r[WIDTH-1] && ((b_r >> 1) != {WIDTH{1'b0}})) begin
            ovf_r <= 1'b1;
          end
          cnt_r   <= cnt_r + CW'(1);
          state_r <= (cnt_r < CW'(WIDTH - 1)) ? MADD : DONE;
        end
        DONE: begin
          if (!resp_valid_r) begin
            resp_valid_r <= 1'b1;
            resp_data_r  <= acc_r;
            resp_zero_r  <= is_zero(acc_r);
            resp_neg_r   <= acc_r[WIDTH-1];
            resp_ovf_r   <= (op_r == OP_MUL) ? ovf_r : 1'b0;
          end else if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_zero  = resp_zero_r;
  assign bus.resp_neg   = resp_neg_r;
  assign bus.resp_ovf   = resp_ovf_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed self-checking bench for alu_seq_ctrl with a
// behavioural single-step ALU attached to the ALU port.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  alu_in1;
  logic [7:0]  alu_in2;
  alu_opcode_t alu_op;
  logic [7:0]  alu_out;
  alu_flags_t  alu_flags;
  logic [8:0]  sum9;
  int          checks;
  int          failures;

  alu_seq_ctrl_if #(.WIDTH(8)) bus ();

  alu_seq_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_flags (alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-step ALU: add with carry, shifts by one bit.
  always_comb begin
    sum9    = {1'b0, alu_in1} + {1'b0, alu_in2};
    alu_out = 8'h00;
    case (alu_op)
      ALU_ADD: alu_out = sum9[7:0];
      ALU_SLL: alu_out = {alu_in1[6:0], 1'b0};
      ALU_SRL: alu_out = {1'b0, alu_in1[7:1]};
      ALU_SRA: alu_out = {alu_in1[7], alu_in1[7:1]};
      default: alu_out = 8'h00;
    endcase
    alu_flags.carry = (alu_op == ALU_ADD) ? sum9[8] : 1'b0;
    alu_flags.zero  = (alu_out == 8'h00);
    alu_flags.neg   = alu_out[7];
    alu_flags.ovf   = 1'b0;
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Present a request, wait (bounded) for acceptance; returns #1 after the accept edge.
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int guard;
    guard = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge clk);
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk1("accept_timeout", (guard < 100), 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Count cycles from the accept edge to resp_valid (bounded).
  task automatic wait_resp(input string tag, input int exp_lat);
    int cyc;
    cyc = 0;
    while (!bus.resp_valid && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk8({tag, "_latency"}, 8'(cyc), 8'(exp_lat));
  endtask

  task automatic check_resp(input string tag, input logic [7:0] d, input logic z,
                            input logic n, input logic o);
    chk1({tag, "_valid"}, bus.resp_valid, 1'b1);
    chk8({tag, "_data"}, bus.resp_data, d);
    chk1({tag, "_zero"}, bus.resp_zero, z);
    chk1({tag, "_neg"}, bus.resp_neg, n);
    chk1({tag, "_ovf"}, bus.resp_ovf, o);
  endtask

  task automatic handoff(input string tag);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk1({tag, "_post_valid"}, bus.resp_valid, 1'b0);
    chk1({tag, "_post_ready"}, bus.req_ready, 1'b1);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_a      = 8'h00;
    bus.req_b      = 8'h00;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("rst_req_ready", bus.req_ready, 1'b1);
    chk1("rst_resp_valid", bus.resp_valid, 1'b0);
    chk8("rst_resp_data", bus.resp_data, 8'h00);
    chk1("rst_resp_zero", bus.resp_zero, 1'b0);
    chk1("rst_resp_neg", bus.resp_neg, 1'b0);
    chk1("rst_resp_ovf", bus.resp_ovf, 1'b0);

    // SLL_N 0x81 by 3
    send(2'b00, 8'h81, 8'd3);
    wait_resp("sll3", 4);
    check_resp("sll3", 8'h08, 1'b0, 1'b0, 1'b0);
    handoff("sll3");

    // SRA_N 0x90 by 2
    send(2'b10, 8'h90, 8'd2);
    wait_resp("sra2", 3);
    check_resp("sra2", 8'hE4, 1'b0, 1'b1, 1'b0);
    handoff("sra2");

    // SRA_N 0x80 by 200 (clamped to 8)
    send(2'b10, 8'h80, 8'd200);
    wait_resp("sra200", 9);
    check_resp("sra200", 8'hFF, 1'b0, 1'b1, 1'b0);
    handoff("sra200");

    // SRL_N by 0 passes the value through
    send(2'b01, 8'h5A, 8'd0);
    wait_resp("srl0", 1);
    check_resp("srl0", 8'h5A, 1'b0, 1'b0, 1'b0);
    handoff("srl0");

    // MUL 13 * 11 = 143
    send(2'b11, 8'd13, 8'd11);
    wait_resp("mul13x11", 17);
    check_resp("mul13x11", 8'h8F, 1'b0, 1'b1, 1'b0);
    handoff("mul13x11");

    // MUL 0x10 * 0x10 = 0x100 -> overflow
    send(2'b11, 8'h10, 8'h10);
    wait_resp("mul16x16", 17);
    check_resp("mul16x16", 8'h00, 1'b1, 1'b0, 1'b1);
    handoff("mul16x16");

    // Backpressure and back-to-back: MUL 7 * 9 = 63, then SRL_N 0xF0 by 4 held pending
    send(2'b11, 8'd7, 8'd9);
    wait_resp("mul7x9", 17);
    check_resp("mul7x9", 8'h3F, 1'b0, 1'b0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_a     = 8'hF0;
    bus.req_b     = 8'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk8("bp_data_stable", bus.resp_data, 8'h3F);
      chk1("bp_valid_held", bus.resp_valid, 1'b1);
      chk1("bp_req_ready_low", bus.req_ready, 1'b0);
    end
    handoff("mul7x9");
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk1("b2b_accepted", bus.req_ready, 1'b0);
    wait_resp("b2b_srl4", 5);
    check_resp("b2b_srl4", 8'h0F, 1'b0, 1'b0, 1'b0);
    handoff("b2b_srl4");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk1("no_extra_resp", bus.resp_valid, 1'b0);
    end

    // Reset during MADD aborts the multiply
    send(2'b11, 8'd13, 8'd11);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("abort_resp_valid", bus.resp_valid, 1'b0);
    chk1("abort_req_ready", bus.req_ready, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk1("abort_no_resp", bus.resp_valid, 1'b0);
    end
    send(2'b01, 8'h80, 8'd7);
    wait_resp("srl7", 8);
    check_resp("srl7", 8'h01, 1'b0, 1'b0, 1'b0);
    handoff("srl7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
